stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter: DATA_W, 16, memory word width; PC width is 2*DATA_W.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 instr_valid  input  1  decoded stack instruction present.
REQ-005 op  input  3  000 NOP, 001 CALL, 010 INT, 011 RET, 100 RTI, 101 PUSH, 110 POP; 111 treated as NOP.
REQ-006 pc  input  32  return PC to save (CALL/INT).
REQ-007 flags  input  4  flags to save (INT).
REQ-008 mem_read_data  input  16  word returned by the memory stage (combinational read).
REQ-009 stall  output  1  freeze upstream pipeline.
REQ-010 stack_signal, dec_sp, inc_sp, mem_write, mem_read  output  1 each  memory-stage controls.
REQ-011 which_data1, which_data2  output  1 each  write-data select: {which_data2,which_data1} 00 input_data, 01 pc_low, 10 pc_high, 11 flags.
REQ-012 pc_low_out, pc_high_out  output  16 each  latched pc[15:0], pc[31:16].
REQ-013 flags_out  output  4  latched flags for push.
REQ-014 pc_ret  output  32  PC assembled from pops.
REQ-015 flags_ret  output  4  flags popped by RTI.
REQ-016 pop_data  output  16  word popped by POP.
REQ-017 pc_load, flags_load, pop_valid  output  1 each  one-cycle completion strobes.

Function
REQ-018 States: IDLE, PUSH_F, PUSH_H, PUSH_L, POP_L, POP_H, POP_F, POP_D, DONE; registered state, Moore outputs except stall.
REQ-019 Accept only in IDLE when instr_valid=1 and op not NOP; on accept latch op, pc, flags; no memory op in accept cycle.
REQ-020 Next state from IDLE on accept: CALL->PUSH_H, INT->PUSH_F, PUSH->PUSH_L with select 00, RET/RTI->POP_L, POP->POP_D.
REQ-021 Sequences: INT PUSH_F->PUSH_H->PUSH_L->IDLE; CALL PUSH_H->PUSH_L->IDLE; PUSH PUSH_L->IDLE; RET POP_L->POP_H->DONE; RTI POP_L->POP_H->POP_F->DONE; POP POP_D->DONE; DONE->IDLE.
REQ-022 Push states: stack_signal=1, mem_write=1, dec_sp=1, mem_read=0, inc_sp=0; select 11 in PUSH_F, 10 in PUSH_H, 01 in PUSH_L (00 when op=PUSH).
REQ-023 Pop states: stack_signal=1, mem_read=1, inc_sp=1, mem_write=0, dec_sp=0; mem_read_data captured at clock edge ending the state: POP_L->pc_ret[15:0], POP_H->pc_ret[31:16], POP_F->flags_ret (bits 3:0), POP_D->pop_data.
REQ-024 DONE: pc_load=1 for RET/RTI, flags_load=1 for RTI only, pop_valid=1 for POP only; all memory controls 0.
REQ-025 IDLE: all memory controls and strobes 0.
REQ-026 dec_sp and inc_sp never both 1; mem_write and mem_read never both 1.
REQ-027 stall = (state != IDLE) OR (state == IDLE AND instr_valid AND op not NOP); combinational.
REQ-028 Inputs pc, flags, op ignored while not IDLE; new instruction accepted in the cycle state returns to IDLE (back-to-back allowed).
REQ-029 Latency from accept edge to IDLE: PUSH 2, CALL 3, INT 4, POP 3, RET 4, RTI 5 cycles.
REQ-030 pc_ret, flags_ret, pop_data hold value until overwritten by a later pop.

Reset
REQ-031 rst=0 asynchronously forces IDLE; clears latched op, pc_low_out, pc_high_out, flags_out, pc_ret, flags_ret, pop_data to 0; all 1-bit outputs 0 except stall follows REQ-027 with state IDLE.
REQ-032 Reset mid-sequence aborts with no further memory ops; no completion strobe issued.

Verification
REQ-033 CALL, pc=0x0001_2345 -> cycle1 mem_write, dec_sp, select 10, pc_high_out=0x0001; cycle2 select 01, pc_low_out=0x2345; cycle3 IDLE, stall=0.
REQ-034 INT, flags=0xA -> three pushes, selects 11,10,01 in order; flags_out=0xA; stall high 4 cycles including accept.
REQ-035 RTI, mem_read_data 0x2345, 0x0001, 0x000A in successive pop cycles -> DONE: pc_ret=0x0001_2345, flags_ret=0xA, pc_load=1, flags_load=1 for exactly one cycle.
REQ-036 POP with mem_read_data=0xBEEF -> pop_valid pulse, pop_data=0xBEEF; pc_load=0.
REQ-037 rst low during PUSH_H of CALL -> immediately IDLE, mem_write=0, outputs cleared; after release, new RET completes normally.
REQ-038 CALL immediately followed by RET with instr_valid held -> RET accepted on the cycle CALL returns to IDLE; assertion checks REQ-026 every cycle.

Source files
------------

// File: rtl/stack_sequencer.sv
// stack_sequencer: sequences the multi-word stack pushes and pops for CALL/INT/RET/RTI/PUSH/POP,
// latching the return context on entry and reassembling it from successive pops.
module stack_sequencer #(
   parameter int DATA_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   input  logic [2:0]          op,
   input  logic [2*DATA_W-1:0] pc,
   input  logic [3:0]          flags,
   input  logic [DATA_W-1:0]   mem_read_data,
   output logic                stall,
   output logic                stack_signal,
   output logic                dec_sp,
   output logic                inc_sp,
   output logic                mem_write,
   output logic                mem_read,
   output logic                which_data1,
   output logic                which_data2,
   output logic [DATA_W-1:0]   pc_low_out,
   output logic [DATA_W-1:0]   pc_high_out,
   output logic [3:0]          flags_out,
   output logic [2*DATA_W-1:0] pc_ret,
   output logic [3:0]          flags_ret,
   output logic [DATA_W-1:0]   pop_data,
   output logic                pc_load,
   output logic                flags_load,
   output logic                pop_valid
);
   localparam logic [2:0] OP_NOP = 3'd0, OP_CALL = 3'd1, OP_INT = 3'd2, OP_RET = 3'd3,
                          OP_RTI = 3'd4, OP_PUSH = 3'd5, OP_POP = 3'd6, OP_NOP2 = 3'd7;
   typedef enum logic [3:0] {IDLE, PUSH_F, PUSH_H, PUSH_L, POP_L, POP_H, POP_F, POP_D, DONE} state_t;
   state_t state, nxt;
   logic [2:0] op_q;
   logic accept, push, pop;
   assign accept = instr_valid && op != OP_NOP && op != OP_NOP2;
   // stall is the only Mealy output: it must rise in the accept cycle itself
   assign stall = state != IDLE || accept;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= nxt;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:         if (accept) nxt = op == OP_CALL ? PUSH_H : op == OP_INT ? PUSH_F :
                                         op == OP_PUSH ? PUSH_L : op == OP_POP ? POP_D : POP_L;
         PUSH_F:       nxt = PUSH_H;
         PUSH_H:       nxt = PUSH_L;
         POP_L:        nxt = POP_H;
         POP_H:        nxt = op_q == OP_RTI ? POP_F : DONE;
         POP_F, POP_D: nxt = DONE;
         default:      nxt = IDLE;
      endcase
   end
   always_comb begin
      push = state inside {PUSH_F, PUSH_H, PUSH_L};
      pop = state inside {POP_L, POP_H, POP_F, POP_D};
      stack_signal = push || pop;
      mem_write = push;
      dec_sp = push;
      mem_read = pop;
      inc_sp = pop;
      which_data2 = state == PUSH_F || state == PUSH_H;
      which_data1 = state == PUSH_F || (state == PUSH_L && op_q != OP_PUSH);
      pc_load = state == DONE && (op_q == OP_RET || op_q == OP_RTI);
      flags_load = state == DONE && op_q == OP_RTI;
      pop_valid = state == DONE && op_q == OP_POP;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q <= '0;
         pc_low_out <= '0;
         pc_high_out <= '0;
         flags_out <= '0;
         pc_ret <= '0;
         flags_ret <= '0;
         pop_data <= '0;
      end else begin
         if (state == IDLE && accept) begin
            op_q <= op;
            pc_low_out <= pc[DATA_W-1:0];
            pc_high_out <= pc[2*DATA_W-1:DATA_W];
            flags_out <= flags;
         end
         if (state == POP_L) pc_ret[DATA_W-1:0] <= mem_read_data;
         if (state == POP_H) pc_ret[2*DATA_W-1:DATA_W] <= mem_read_data;
         if (state == POP_F) flags_ret <= mem_read_data[3:0];
         if (state == POP_D) pop_data <= mem_read_data;
      end
   end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: vector table, directed corner cases and random traffic checked
// against a step-script model of the stack sequencer.
module tb_stack_sequencer;
   logic clk = 0, rst = 0, instr_valid = 0;
   logic [2:0] op = 0;
   logic [31:0] pc = 0;
   logic [3:0] flags = 0;
   logic [15:0] mem_read_data = 0;
   logic stall, stack_signal, dec_sp, inc_sp, mem_write, mem_read, which_data1, which_data2;
   logic pc_load, flags_load, pop_valid;
   logic [15:0] pc_low_out, pc_high_out, pop_data;
   logic [3:0] flags_out, flags_ret;
   logic [31:0] pc_ret;
   int n_chk = 0, n_fail = 0;

   stack_sequencer #(.DATA_W(16)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .op(op), .pc(pc), .flags(flags),
      .mem_read_data(mem_read_data), .stall(stall), .stack_signal(stack_signal), .dec_sp(dec_sp),
      .inc_sp(inc_sp), .mem_write(mem_write), .mem_read(mem_read), .which_data1(which_data1),
      .which_data2(which_data2), .pc_low_out(pc_low_out), .pc_high_out(pc_high_out),
      .flags_out(flags_out), .pc_ret(pc_ret), .flags_ret(flags_ret), .pop_data(pop_data),
      .pc_load(pc_load), .flags_load(flags_load), .pop_valid(pop_valid));

   always #5 clk = ~clk;

   typedef struct packed {
      logic stall, ss, dec, inc, mw, mr;
      logic [1:0] sel;
      logic pcl, fll, popv;
   } ctl_t;
   typedef struct packed {
      logic iv;
      logic [2:0] op;
      logic [31:0] pc;
      logic [3:0] fl;
      logic [15:0] d;
      ctl_t e;
   } vec_t;
   typedef enum logic [2:0] {K_PUSH, K_POPL, K_POPH, K_POPF, K_POPD, K_DONE} kind_t;
   typedef struct packed {
      kind_t k;
      logic [1:0] sel;
      logic [2:0] sb;
   } step_t;

   ctl_t dut_ctl;
   assign dut_ctl = {stall, stack_signal, dec_sp, inc_sp, mem_write, mem_read, which_data2, which_data1,
                     pc_load, flags_load, pop_valid};

   // model: an accepted instruction becomes a script of steps, one step per cycle
   step_t q[$];
   logic [15:0] m_pcl, m_pch, m_pop;
   logic [3:0] m_fl, m_flr;
   logic [31:0] m_pcr;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic step_t st(input kind_t k, input logic [1:0] sel, input logic [2:0] sb);
      return {k, sel, sb};
   endfunction

   function automatic vec_t v(input logic iv, input logic [2:0] o, input logic [31:0] p,
                              input logic [3:0] f, input logic [15:0] d, input logic [10:0] e);
      return {iv, o, p, f, d, e};
   endfunction

   function automatic logic accepts(input logic iv, input logic [2:0] o);
      return iv && o != 3'd0 && o != 3'd7;
   endfunction

   task automatic model_reset();
      q.delete();
      {m_pcl, m_pch, m_pop, m_fl, m_flr, m_pcr} = '0;
   endtask

   function automatic ctl_t model_ctl();
      ctl_t c = '0;
      if (q.size() == 0) c.stall = accepts(instr_valid, op);
      else begin
         c.stall = 1'b1;
         case (q[0].k)
            K_PUSH: begin c.ss = 1; c.dec = 1; c.mw = 1; c.sel = q[0].sel; end
            K_DONE: {c.pcl, c.fll, c.popv} = q[0].sb;
            default: begin c.ss = 1; c.inc = 1; c.mr = 1; end
         endcase
      end
      return c;
   endfunction

   task automatic model_step();
      step_t s;
      if (q.size() == 0) begin
         if (accepts(instr_valid, op)) begin
            m_pcl = pc[15:0];
            m_pch = pc[31:16];
            m_fl = flags;
            case (op)
               3'd1: begin q.push_back(st(K_PUSH, 2'd2, 0)); q.push_back(st(K_PUSH, 2'd1, 0)); end
               3'd2: begin
                  q.push_back(st(K_PUSH, 2'd3, 0)); q.push_back(st(K_PUSH, 2'd2, 0));
                  q.push_back(st(K_PUSH, 2'd1, 0));
               end
               3'd3: begin
                  q.push_back(st(K_POPL, 0, 0)); q.push_back(st(K_POPH, 0, 0));
                  q.push_back(st(K_DONE, 0, 3'b100));
               end
               3'd4: begin
                  q.push_back(st(K_POPL, 0, 0)); q.push_back(st(K_POPH, 0, 0));
                  q.push_back(st(K_POPF, 0, 0)); q.push_back(st(K_DONE, 0, 3'b110));
               end
               3'd5: q.push_back(st(K_PUSH, 2'd0, 0));
               default: begin q.push_back(st(K_POPD, 0, 0)); q.push_back(st(K_DONE, 0, 3'b001)); end
            endcase
         end
      end else begin
         s = q.pop_front();
         case (s.k)
            K_POPL: m_pcr[15:0] = mem_read_data;
            K_POPH: m_pcr[31:16] = mem_read_data;
            K_POPF: m_flr = mem_read_data[3:0];
            K_POPD: m_pop = mem_read_data;
            default: ;
         endcase
      end
   endtask

   task automatic cycle(input logic iv, input logic [2:0] o, input logic [31:0] p, input logic [3:0] f,
                        input logic [15:0] d, input ctl_t texp, input logic use_t);
      instr_valid = iv; op = o; pc = p; flags = f; mem_read_data = d;
      @(negedge clk);
      chk("ctl_vs_model", 32'(dut_ctl), 32'(model_ctl()));
      if (use_t) chk("ctl_vs_table", 32'(dut_ctl), 32'(texp));
      chk("sp_exclusive", 32'(dec_sp & inc_sp), 32'd0);
      chk("rw_exclusive", 32'(mem_write & mem_read), 32'd0);
      chk("pc_low_out", 32'(pc_low_out), 32'(m_pcl));
      chk("pc_high_out", 32'(pc_high_out), 32'(m_pch));
      chk("flags_out", 32'(flags_out), 32'(m_fl));
      chk("pc_ret", pc_ret, m_pcr);
      chk("flags_ret", 32'(flags_ret), 32'(m_flr));
      chk("pop_data", 32'(pop_data), 32'(m_pop));
      @(posedge clk);
      model_step();
      #1;
   endtask

   initial begin
      model_reset();
      #3;
      chk("reset_ctl", 32'(dut_ctl), 32'd0);
      chk("reset_pc_ret", pc_ret, 32'd0);
      chk("reset_pop_data", 32'(pop_data), 32'd0);
      instr_valid = 1; op = 3'd1;
      #1;
      chk("reset_stall_follows_input", 32'(stall), 32'd1);
      instr_valid = 0; op = 0;
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      // CALL, INT, RTI, POP, PUSH, NOPs, then CALL with RET held behind it
      tbl.push_back(v(1, 3'd1, 32'h0001_2345, 4'h0, 16'h0, 11'b100000_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b111010_10_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b111010_01_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b000000_00_000));
      tbl.push_back(v(1, 3'd2, 32'h0005_6789, 4'hA, 16'h0, 11'b100000_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b111010_11_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b111010_10_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b111010_01_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b000000_00_000));
      tbl.push_back(v(1, 3'd4, 32'h0, 4'h0, 16'h0, 11'b100000_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h2345, 11'b110101_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0001, 11'b110101_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h000A, 11'b110101_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b100000_00_110));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b000000_00_000));
      tbl.push_back(v(1, 3'd6, 32'h0, 4'h0, 16'h0, 11'b100000_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'hBEEF, 11'b110101_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b100000_00_001));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b000000_00_000));
      tbl.push_back(v(1, 3'd5, 32'h0, 4'h0, 16'h0, 11'b100000_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b111010_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b000000_00_000));
      tbl.push_back(v(1, 3'd0, 32'h0, 4'h0, 16'h0, 11'b000000_00_000));
      tbl.push_back(v(1, 3'd7, 32'h0, 4'h0, 16'h0, 11'b000000_00_000));
      tbl.push_back(v(1, 3'd1, 32'h00AB_CDEF, 4'h3, 16'h0, 11'b100000_00_000));
      tbl.push_back(v(1, 3'd3, 32'h00AB_CDEF, 4'h3, 16'h0, 11'b111010_10_000));
      tbl.push_back(v(1, 3'd3, 32'h00AB_CDEF, 4'h3, 16'h0, 11'b111010_01_000));
      tbl.push_back(v(1, 3'd3, 32'h00AB_CDEF, 4'h3, 16'h0, 11'b100000_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h1111, 11'b110101_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h2222, 11'b110101_00_000));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b100000_00_100));
      tbl.push_back(v(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b000000_00_000));
      foreach (tbl[i]) cycle(tbl[i].iv, tbl[i].op, tbl[i].pc, tbl[i].fl, tbl[i].d, tbl[i].e, 1'b1);
      chk("tbl_pc_ret", pc_ret, 32'h2222_1111);
      chk("tbl_flags_ret", 32'(flags_ret), 32'hA);
      chk("tbl_pop_data", 32'(pop_data), 32'hBEEF);
      chk("tbl_pc_high_out", 32'(pc_high_out), 32'h00AB);
      chk("tbl_pc_low_out", 32'(pc_low_out), 32'hCDEF);
      // asynchronous reset while CALL is pushing the high half
      cycle(1, 3'd1, 32'h0001_2345, 4'h5, 16'h0, '0, 1'b0);
      instr_valid = 0;
      #2;
      chk("pre_reset_mem_write", 32'(mem_write), 32'd1);
      rst = 0;
      #1;
      chk("abort_ctl", 32'(dut_ctl), 32'd0);
      chk("abort_pc_high_out", 32'(pc_high_out), 32'd0);
      chk("abort_flags_out", 32'(flags_out), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      cycle(1, 3'd3, 32'h0, 4'h0, 16'h0, 11'b100000_00_000, 1'b1);
      cycle(0, 3'd0, 32'h0, 4'h0, 16'h5678, 11'b110101_00_000, 1'b1);
      cycle(0, 3'd0, 32'h0, 4'h0, 16'h0009, 11'b110101_00_000, 1'b1);
      cycle(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b100000_00_100, 1'b1);
      cycle(0, 3'd0, 32'h0, 4'h0, 16'h0, 11'b000000_00_000, 1'b1);
      chk("post_reset_ret_pc", pc_ret, 32'h0009_5678);
      for (int i = 0; i < 3000; i++)
         cycle(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom, 4'($urandom),
               16'($urandom), '0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
